// File: rtl/ex_pkg.sv
// Shared encodings for the multiply/divide unit: FSM states and operation codes.
// Latency: none (types and a pure decode function only).
// Backpressure: not applicable.
package ex_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_MULT    = 2'd0,
    OP_DIV     = 2'd1,
    OP_ILLEGAL = 2'd2
  } op_t;

  // Exactly one of the two request bits must be set for a real operation.
  function automatic op_t decode_op(input logic mult, input logic div);
    if (mult && !div) return OP_MULT;
    if (div && !mult) return OP_DIV;
    return OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: multiply = conditional add then right shift,
// divide = left shift then conditional (restoring) subtract. Purely combinational.
// Ports: i_div selects divide; i_acc/i_mq/i_md = accumulator, multiplier-or-quotient, operand; o_* = next values.
module ex_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mq,
  input  logic [WIDTH-1:0] i_md,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mq
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_sum  = {1'b0, i_acc} + {1'b0, i_md};
  assign w_shl  = {i_acc, i_mq[WIDTH-1]};
  assign w_ge   = (w_shl >= {1'b0, i_md});
  // The partial remainder is always below the divisor, so the difference fits in WIDTH bits.
  assign w_diff = w_shl[WIDTH-1:0] - i_md;

  always_comb begin
    o_acc = i_acc;
    o_mq  = i_mq;
    if (i_div) begin
      o_acc = w_ge ? w_diff : w_shl[WIDTH-1:0];
      o_mq  = {i_mq[WIDTH-2:0], w_ge};
    end else if (i_mq[0]) begin
      o_acc = w_sum[WIDTH:1];
      o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[WIDTH-1:1]};
      o_mq  = {i_acc[0], i_mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide; one request in flight at a time.
// Latency: result valid WIDTH+2 edges after the accepting edge (illegal op: DONE on the accepting edge).
// Backpressure: InValid/InReady in, OutValid/OutReady out; result held while OutReady is low.
// Ports: Clk, Reset (sync, active-low), request (InValid, InReady, OpMult, OpDiv, OpUnsigned, Op1, Op2, DstIn),
//        Flush, result (OutValid, OutReady, Lo, Hi, DstOut, DivByZero), Busy.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DSTW  = 5
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic            OpMult,
  input  logic            OpDiv,
  input  logic            OpUnsigned,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic [DSTW-1:0] DstIn,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic [DSTW-1:0] DstOut,
  output logic            DivByZero,
  output logic            Busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_next;
  op_t              r_op, w_in_op;
  logic [CW-1:0]    r_cnt;
  logic             r_uns, r_neg_q, r_neg_r, r_zero;
  logic [WIDTH-1:0] r_acc, r_mq, r_md;
  logic [WIDTH-1:0] r_lo, r_hi;
  logic [DSTW-1:0]  r_dst;
  logic             r_dbz;
  logic             w_accept, w_is_div;
  logic [WIDTH-1:0] w_step_acc, w_step_mq, w_mag1, w_mag2, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod;

  assign w_in_op  = decode_op(OpMult, OpDiv);
  assign w_accept = InValid & InReady;
  assign w_is_div = (r_op == OP_DIV);

  // In PREP r_mq/r_md still hold the raw operands; convert to magnitudes when signed.
  assign w_mag1 = (!r_uns && r_mq[WIDTH-1]) ? -r_mq : r_mq;
  assign w_mag2 = (!r_uns && r_md[WIDTH-1]) ? -r_md : r_md;

  // Sign correction of the magnitude results. A zero divisor restores Hi to the
  // original dividend because the restoring loop shifts the whole dividend into r_acc.
  assign w_prod = r_neg_q ? -{r_acc, r_mq} : {r_acc, r_mq};
  assign w_quo  = r_zero ? '1 : (r_neg_q ? -r_mq : r_mq);
  assign w_rem  = r_neg_r ? -r_acc : r_acc;

  ex_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (w_is_div),
    .i_acc (r_acc),
    .i_mq  (r_mq),
    .i_md  (r_md),
    .o_acc (w_step_acc),
    .o_mq  (w_step_mq)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    InReady  = Reset & ~Flush & ((r_state == S_IDLE) | ((r_state == S_DONE) & OutReady));
    OutValid = (r_state == S_DONE) & ~Flush;
    Busy     = Reset & (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (InValid && InReady) w_next = (w_in_op == OP_ILLEGAL) ? S_DONE : S_PREP;
      S_PREP: w_next = S_ITER;
      S_ITER: if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        if (OutReady) begin
          if (InValid && InReady) w_next = (w_in_op == OP_ILLEGAL) ? S_DONE : S_PREP;
          else                    w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (Flush) w_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_op    <= OP_MULT;
      r_uns   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_md    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_dst   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_op  <= w_in_op;
      r_uns <= OpUnsigned;
      r_mq  <= Op1;
      r_md  <= Op2;
      r_dst <= DstIn;
      if (w_in_op == OP_ILLEGAL) begin
        r_lo  <= '0;
        r_hi  <= '0;
        r_dbz <= 1'b0;
      end
    end else if (!Flush) begin
      case (r_state)
        S_PREP: begin
          r_acc   <= '0;
          r_mq    <= w_mag1;
          r_md    <= w_mag2;
          r_cnt   <= '0;
          r_neg_q <= !r_uns && (r_mq[WIDTH-1] ^ r_md[WIDTH-1]);
          r_neg_r <= !r_uns && r_mq[WIDTH-1];
          r_zero  <= w_is_div && (r_md == '0);
        end
        S_ITER: begin
          r_acc <= w_step_acc;
          r_mq  <= w_step_mq;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (w_is_div) begin
            r_lo  <= w_quo;
            r_hi  <= w_rem;
            r_dbz <= r_zero;
          end else begin
            r_lo  <= w_prod[WIDTH-1:0];
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Lo        = r_lo;
  assign Hi        = r_hi;
  assign DstOut    = r_dst;
  assign DivByZero = r_dbz;

endmodule
